dio24_fifo_reset_responder: RTL



---
 rtl/dio24_fifo_reset_responder_pkg.sv | 34 +++
 rtl/dio24_fifo_reset_responder_if.sv | 48 ++++
 rtl/dio24_sat_counter.sv | 29 ++
 rtl/dio24_fifo_reset_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dio24_fifo_reset_responder_pkg.sv
// Shared types and helpers for the FIFO reset responder and the reset generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package dio24_fifo_reset_responder_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_ASSERT = 3'd2,
        S_WAIT   = 3'd3,
        S_POST   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Number of bits needed to hold 'value' (1023 -> 10, 8 -> 4)
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dio24_fifo_reset_responder_if.sv
// Bundle of request/ack, producer/consumer enables and FIFO-primitive control lines.
// Latency: n/a (wires only).
// Backpressure: n/a; the responder gates the enables itself.
interface dio24_fifo_reset_responder_if;

    logic reset_req;
    logic reset_ack;
    logic reset_error;
    logic in_wr_en;
    logic in_rd_en;
    logic fifo_wr_en;
    logic fifo_rd_en;
    logic fifo_rst;
    logic fifo_wr_rst_busy;
    logic fifo_rd_rst_busy;
    logic fifo_ready;

    // Responder side: drives the FIFO controls and the acknowledge
    modport master (
        input  reset_req,
        input  in_wr_en,
        input  in_rd_en,
        input  fifo_wr_rst_busy,
        input  fifo_rd_rst_busy,
        output reset_ack,
        output reset_error,
        output fifo_wr_en,
        output fifo_rd_en,
        output fifo_rst,
        output fifo_ready
    );

    // Surrounding logic: requester, stream endpoints and FIFO status
    modport slave (
        output reset_req,
        output in_wr_en,
        output in_rd_en,
        output fifo_wr_rst_busy,
        output fifo_rd_rst_busy,
        input  reset_ack,
        input  reset_error,
        input  fifo_wr_en,
        input  fifo_rd_en,
        input  fifo_rst,
        input  fifo_ready
    );

endinterface

// File: rtl/dio24_sat_counter.sv
// Saturating up-counter with synchronous clear, used for guard and timeout windows.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module dio24_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Clear has priority; increment stops at the top value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dio24_fifo_reset_responder.sv
// Sequences a dual-clock FIFO reset: gate enables, pulse fifo_rst, wait busy-clear, reopen, ack.
// Latency: status outputs registered (1 cycle); wr/rd enables are combinational through the gate.
// Backpressure: enables forced low whenever fifo_ready is low; requests mid-sequence are ignored.
module dio24_fifo_reset_responder
    import dio24_fifo_reset_responder_pkg::*;
#(
    parameter int FIFO_RESET_DELAY  = 4,     // >= 4
    parameter int FIFO_RESET_CYCLES = 5,     // >= 5
    parameter int FIFO_POST_DELAY   = 2,     // >= 2
    parameter int BUSY_TIMEOUT      = 1023   // >= 1
) (
    input  logic                               clock_slow,
    input  logic                               reset,
    dio24_fifo_reset_responder_if.master       bus
);

    localparam int MAX_PARAM = max2(max2(FIFO_RESET_DELAY, FIFO_RESET_CYCLES),
                                    max2(FIFO_POST_DELAY, BUSY_TIMEOUT));
    localparam int CNT_W     = clogb2(MAX_PARAM);

    // Counter value seen in the last cycle of each timed state
    localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(FIFO_RESET_DELAY - 1);
    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(FIFO_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST   = CNT_W'(FIFO_POST_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(BUSY_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_clr;
    logic             r_req_d;
    logic             w_req_rise;
    logic             w_busy_clear;

    logic             r_fifo_rst;
    logic             r_fifo_ready;
    logic             r_reset_ack;
    logic             r_reset_error;
    logic             w_fifo_rst_nxt;
    logic             w_fifo_ready_nxt;
    logic             w_reset_ack_nxt;
    logic             w_reset_error_nxt;

    assign w_busy_clear = !bus.fifo_wr_rst_busy && !bus.fifo_rd_rst_busy;
    assign w_req_rise   = bus.reset_req && !r_req_d;
    assign w_cnt_clr    = (w_state_nxt != r_state);

    // One counter serves every timed state; it restarts on each state change
    dio24_sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clock_slow),
        .rst   (reset),
        .i_clr (w_cnt_clr),
        .i_en  (1'b1),
        .o_cnt (w_cnt)
    );

    // Previous request level; only the ERR exit cares about the edge
    always_ff @(posedge clock_slow or posedge reset) begin
        if (reset) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= bus.reset_req;
        end
    end

    // State register; module reset starts a full power-on sequence from PRE
    always_ff @(posedge clock_slow or posedge reset) begin
        if (reset) begin
            r_state <= S_PRE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; busy flags matter only in WAIT, where a clear FIFO beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.reset_req)          w_state_nxt = S_PRE;
            S_PRE:    if (w_cnt == PRE_LAST)      w_state_nxt = S_ASSERT;
            S_ASSERT: if (w_cnt == ASSERT_LAST)   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_busy_clear) begin
                    w_state_nxt = S_POST;
                end else if (w_cnt == WAIT_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_POST:   if (w_cnt == POST_LAST)     w_state_nxt = bus.reset_req ? S_DONE : S_IDLE;
            S_DONE:   if (!bus.reset_req)         w_state_nxt = S_IDLE;
            S_ERR:    if (w_req_rise)             w_state_nxt = S_PRE;
            default:                              w_state_nxt = S_PRE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_fifo_rst_nxt    = (w_state_nxt == S_ASSERT);
        w_fifo_ready_nxt  = (w_state_nxt == S_IDLE);
        w_reset_ack_nxt   = (w_state_nxt == S_DONE) ||
                            ((w_state_nxt == S_ERR) && bus.reset_req);
        w_reset_error_nxt = r_reset_error;
        if (w_state_nxt == S_ERR) begin
            w_reset_error_nxt = 1'b1;
        end else if (w_state_nxt == S_PRE) begin
            w_reset_error_nxt = 1'b0;
        end
    end

    // Registered status outputs
    always_ff @(posedge clock_slow or posedge reset) begin
        if (reset) begin
            r_fifo_rst    <= 1'b0;
            r_fifo_ready  <= 1'b0;
            r_reset_ack   <= 1'b0;
            r_reset_error <= 1'b0;
        end else begin
            r_fifo_rst    <= w_fifo_rst_nxt;
            r_fifo_ready  <= w_fifo_ready_nxt;
            r_reset_ack   <= w_reset_ack_nxt;
            r_reset_error <= w_reset_error_nxt;
        end
    end

    assign bus.fifo_rst    = r_fifo_rst;
    assign bus.fifo_ready  = r_fifo_ready;
    assign bus.reset_ack   = r_reset_ack;
    assign bus.reset_error = r_reset_error;

    // Enables pass only while the FIFO is declared usable
    assign bus.fifo_wr_en  = bus.in_wr_en && r_fifo_ready;
    assign bus.fifo_rd_en  = bus.in_rd_en && r_fifo_ready;

endmodule
